// File: rtl/horno_pkg.sv
// horno_pkg
// Shared definitions for the microwave-oven controller:
//   - estado_t and the state codes INICIO..FIN. These are the legacy
//     encodings that the existing display decoders expect.
//   - Default values for the horno_ctrl parameters.
package horno_pkg;

  typedef logic [3:0] estado_t;

  localparam estado_t INICIO   = 4'b0000;
  localparam estado_t AJUSTE   = 4'b0001;
  localparam estado_t PAUSA    = 4'b0010;
  localparam estado_t CALENTAR = 4'b0100;
  localparam estado_t FIN      = 4'b1000;

  localparam int TICK_DIV_DEF = 100_000_000;
  localparam int TW_DEF       = 10;
  localparam int STEP_DEF     = 10;
  localparam int T_MAX_DEF    = 990;
  localparam int QUICK_DEF    = 30;
  localparam int ALARM_S_DEF  = 3;

endpackage

// File: rtl/horno_ctrl_flanco_subida.sv
// flanco_subida
// Rising-edge detector for a debounced, Clk-synchronous button.
// The history register resets to 1. A button that is already held
// when reset is released therefore produces no pulse.
// Ports:
//   Clk     - system clock
//   reset   - asynchronous, active-high reset
//   d_i     - button level
//   pulse_o - high for the cycle in which d_i is 1 and was 0 at the previous edge
module flanco_subida (
  input  logic Clk,
  input  logic reset,
  input  logic d_i,
  output logic pulse_o
);

  logic hist_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) hist_q <= 1'b1;
    else       hist_q <= d_i;
  end

  assign pulse_o = d_i & ~hist_q;

endmodule

// File: rtl/horno_ctrl.sv
// horno_ctrl
// Microwave-oven controller. It provides:
//   - a programmable cook timer
//   - pause/resume
//   - a door interlock
//   - quick-start and cancel
//   - an end-of-cycle alarm
// Ports:
//   Clk, reset        - clock; asynchronous active-high reset
//   Ajust, Calent     - debounced adjust and start/pause buttons (edge-triggered)
//   Cancel, Puerta    - cancel and door-open inputs (level-sensitive)
//   Estado            - current state. Also usable as the FSM debug view.
//   Tiempo            - remaining seconds
//   Magnetron, Alarma - heater enable and buzzer enable
// Within each state, events take priority in this order:
// Cancel > Puerta > start/pause edge > adjust edge.
module horno_ctrl
  import horno_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int TW       = TW_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int T_MAX    = T_MAX_DEF,
  parameter int QUICK    = QUICK_DEF,
  parameter int ALARM_S  = ALARM_S_DEF
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          Ajust,
  input  logic          Calent,
  input  logic          Cancel,
  input  logic          Puerta,
  output logic [3:0]    Estado,
  output logic [TW-1:0] Tiempo,
  output logic          Magnetron,
  output logic          Alarma
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_S > 1) ? $clog2(ALARM_S) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_END = AW'(ALARM_S - 1);
  localparam logic [TW:0]   STEP_X    = (TW+1)'(STEP);
  localparam logic [TW:0]   T_MAX_X   = (TW+1)'(T_MAX);
  localparam logic [TW-1:0] STEP_T    = TW'(STEP);
  localparam logic [TW-1:0] QUICK_T   = TW'(QUICK);
  localparam logic [TW-1:0] ONE_T     = TW'(1);

  logic aj_r, ca_r;

  flanco_subida u_fl_aj (.Clk(Clk), .reset(reset), .d_i(Ajust),  .pulse_o(aj_r));
  flanco_subida u_fl_ca (.Clk(Clk), .reset(reset), .d_i(Calent), .pulse_o(ca_r));

  estado_t       state_q, state_d;
  logic [TW-1:0] tiempo_q, tiempo_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          mag_q, alarma_q;

  // The sum is computed one bit wider than Tiempo, so adding STEP can
  // never wrap before the compare against T_MAX.
  logic [TW:0]   sum_x;
  logic [TW-1:0] tiempo_sat;
  logic          tick;

  assign sum_x      = {1'b0, tiempo_q} + STEP_X;
  assign tiempo_sat = (sum_x > T_MAX_X) ? T_MAX_X[TW-1:0] : sum_x[TW-1:0];
  assign tick       = (presc_q == PRE_LAST) && ((state_q == CALENTAR) || (state_q == FIN));

  // The prescaler is zero in INICIO and AJUSTE. As a result, entry to
  // CALENTAR from those states always starts a fresh second. PAUSA keeps
  // the count, so a resume continues the partial second.
  always_comb begin
    state_d     = state_q;
    tiempo_d    = tiempo_q;
    presc_d     = '0;
    alarm_cnt_d = '0;
    case (state_q)
      INICIO: begin
        if (!Cancel) begin
          if (ca_r) begin
            if (!Puerta) begin
              state_d  = CALENTAR;
              tiempo_d = QUICK_T;
            end
          end else if (aj_r) begin
            state_d  = AJUSTE;
            tiempo_d = STEP_T;
          end
        end
      end
      AJUSTE: begin
        if (Cancel) begin
          state_d  = INICIO;
          tiempo_d = '0;
        end else if (ca_r) begin
          if (!Puerta) state_d = CALENTAR;
        end else if (aj_r) begin
          tiempo_d = tiempo_sat;
        end
      end
      CALENTAR: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (Cancel) begin
          state_d  = INICIO;
          tiempo_d = '0;
          presc_d  = '0;
        end else begin
          // A tick always decrements, even when a pause happens on the
          // same edge. The final tick beats a pause request.
          if (tick) tiempo_d = tiempo_q - 1'b1;
          if (tick && (tiempo_q == ONE_T)) state_d = FIN;
          else if (Puerta || ca_r)         state_d = PAUSA;
        end
      end
      PAUSA: begin
        presc_d = presc_q;
        if (Cancel) begin
          state_d  = INICIO;
          tiempo_d = '0;
          presc_d  = '0;
        end else if (ca_r) begin
          if (!Puerta) state_d = CALENTAR;
        end else if (aj_r) begin
          tiempo_d = tiempo_sat;
        end
      end
      FIN: begin
        tiempo_d    = '0;
        presc_d     = tick ? '0 : presc_q + 1'b1;
        alarm_cnt_d = alarm_cnt_q;
        if (Cancel || Puerta) begin
          state_d     = INICIO;
          presc_d     = '0;
          alarm_cnt_d = '0;
        end else if (tick) begin
          if (alarm_cnt_q == ALARM_END) begin
            state_d     = INICIO;
            alarm_cnt_d = '0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = INICIO;
        tiempo_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= INICIO;
      tiempo_q    <= '0;
      presc_q     <= '0;
      alarm_cnt_q <= '0;
      mag_q       <= 1'b0;
      alarma_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tiempo_q    <= tiempo_d;
      presc_q     <= presc_d;
      alarm_cnt_q <= alarm_cnt_d;
      mag_q       <= (state_d == CALENTAR);
      alarma_q    <= (state_d == FIN);
    end
  end

  assign Estado    = state_q;
  assign Tiempo    = tiempo_q;
  // The door gates the heater combinationally. The heater turns off in
  // the same cycle the door opens, without waiting for the FSM edge.
  assign Magnetron = mag_q & ~Puerta;
  assign Alarma    = alarma_q;

endmodule

// File: tb/tb_horno_ctrl.sv
module tb_horno_ctrl;

  localparam int TICK_DIV = 4;
  localparam int TW       = 10;
  localparam int STEP     = 10;
  localparam int T_MAX    = 30;
  localparam int QUICK    = 5;
  localparam int ALARM_S  = 2;

  logic          Clk;
  logic          reset;
  logic          Ajust, Calent, Cancel, Puerta;
  logic [3:0]    Estado;
  logic [TW-1:0] Tiempo;
  logic          Magnetron, Alarma;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  horno_ctrl #(
    .TICK_DIV(TICK_DIV), .TW(TW), .STEP(STEP),
    .T_MAX(T_MAX), .QUICK(QUICK), .ALARM_S(ALARM_S)
  ) dut (
    .Clk(Clk), .reset(reset), .Ajust(Ajust), .Calent(Calent),
    .Cancel(Cancel), .Puerta(Puerta), .Estado(Estado), .Tiempo(Tiempo),
    .Magnetron(Magnetron), .Alarma(Alarma)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes, seconds remaining, cycles elapsed in the current second,
  // alarm seconds elapsed.
  localparam int M_INI = 0, M_AJ = 1, M_PAU = 2, M_CAL = 3, M_FIN = 4;
  int m_mode, m_t, m_phase, m_alarm;
  bit m_aj_prev, m_ca_prev;

  function automatic logic [3:0] mode_code(input int m);
    case (m)
      M_AJ:    return 4'b0001;
      M_PAU:   return 4'b0010;
      M_CAL:   return 4'b0100;
      M_FIN:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int add_sat(input int t);
    return (t + STEP > T_MAX) ? T_MAX : t + STEP;
  endfunction

  always @(posedge Clk or posedge reset) begin
    bit aj, ca, sec;
    if (reset) begin
      m_mode = M_INI; m_t = 0; m_phase = 0; m_alarm = 0;
      m_aj_prev = 1; m_ca_prev = 1;
    end else begin
      aj = Ajust && !m_aj_prev;
      ca = Calent && !m_ca_prev;
      m_aj_prev = Ajust;
      m_ca_prev = Calent;
      sec = 0;
      if (m_mode == M_CAL || m_mode == M_FIN) begin
        m_phase++;
        if (m_phase == TICK_DIV) begin m_phase = 0; sec = 1; end
      end
      case (m_mode)
        M_INI: begin
          if (!Cancel) begin
            if (ca) begin
              if (!Puerta) begin m_mode = M_CAL; m_t = QUICK; m_phase = 0; end
            end else if (aj) begin m_mode = M_AJ; m_t = STEP; end
          end
        end
        M_AJ: begin
          if (Cancel) begin m_mode = M_INI; m_t = 0; end
          else if (ca) begin
            if (!Puerta) begin m_mode = M_CAL; m_phase = 0; end
          end else if (aj) m_t = add_sat(m_t);
        end
        M_CAL: begin
          if (Cancel) begin m_mode = M_INI; m_t = 0; end
          else begin
            if (sec) m_t--;
            if (sec && m_t == 0) begin m_mode = M_FIN; m_phase = 0; m_alarm = 0; end
            else if (Puerta || ca) m_mode = M_PAU;
          end
        end
        M_PAU: begin
          if (Cancel) begin m_mode = M_INI; m_t = 0; end
          else if (ca) begin
            if (!Puerta) m_mode = M_CAL;
          end else if (aj) m_t = add_sat(m_t);
        end
        default: begin
          if (Cancel || Puerta) m_mode = M_INI;
          else if (sec) begin
            m_alarm++;
            if (m_alarm == ALARM_S) m_mode = M_INI;
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(posedge Clk) begin
    #2;
    if (cmp_en) begin
      chk("cyc_estado",    Estado,    mode_code(m_mode));
      chk("cyc_tiempo",    Tiempo,    m_t);
      chk("cyc_magnetron", Magnetron, (m_mode == M_CAL) && !Puerta);
      chk("cyc_alarma",    Alarma,    m_mode == M_FIN);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press_aj();
    @(negedge Clk) Ajust = 1'b1;
    @(negedge Clk) Ajust = 1'b0;
  endtask

  task automatic press_ca();
    @(negedge Clk) Calent = 1'b1;
    @(negedge Clk) Calent = 1'b0;
  endtask

  task automatic pulse_cancel();
    @(negedge Clk) Cancel = 1'b1;
    @(negedge Clk) Cancel = 1'b0;
  endtask

  task automatic chk_st(input string name, input logic [3:0] st, input int t);
    chk({name, "_estado"}, Estado, st);
    chk({name, "_tiempo"}, Tiempo, t);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; Ajust = 1'b0; Calent = 1'b0; Cancel = 1'b0; Puerta = 1'b0;
    step(2);
    chk_st("reset", 4'b0000, 0);
    chk("reset_mag", Magnetron, 0);
    chk("reset_alarma", Alarma, 0);
    reset = 1'b0;
    cmp_en = 1;

    // Adjust saturation.
    press_aj(); chk_st("adj1", 4'b0001, 10);
    press_aj(); chk_st("adj2", 4'b0001, 20);
    press_aj(); chk_st("adj3", 4'b0001, 30);
    press_aj(); chk_st("adj4", 4'b0001, 30);
    pulse_cancel(); chk_st("cancel_ajuste", 4'b0000, 0);

    // Full cook: 10 s x 4 cycles, then 2 alarm seconds (8 cycles).
    press_aj();
    press_ca();
    chk_st("cook_start", 4'b0100, 10);
    chk("cook_mag", Magnetron, 1);
    step(39); chk_st("cook_last", 4'b0100, 1);
    step(1);  chk_st("cook_fin", 4'b1000, 0);
    chk("cook_alarma", Alarma, 1);
    chk("cook_mag_off", Magnetron, 0);
    step(7);  chk("alarm_still", Alarma, 1);
    step(1);  chk_st("alarm_done", 4'b0000, 0);
    chk("alarm_off", Alarma, 0);

    // Quick-start: blocked with the door open, then accepted.
    @(negedge Clk) Puerta = 1'b1;
    press_ca(); chk_st("quick_door", 4'b0000, 0);
    @(negedge Clk) Puerta = 1'b0;
    press_ca(); chk_st("quick", 4'b0100, 5);

    // Door interlock mid-cook, with the phase preserved on resume.
    step(5); chk_st("door_pre", 4'b0100, 4);
    Puerta = 1'b1;
    #1 chk("door_mag_now", Magnetron, 0);
    @(negedge Clk) chk_st("door_pausa", 4'b0010, 4);
    step(10); chk_st("door_frozen", 4'b0010, 4);
    press_ca(); chk_st("door_ca_ignored", 4'b0010, 4);
    @(negedge Clk) begin Puerta = 1'b0; Calent = 1'b1; end
    @(negedge Clk) Calent = 1'b0;
    chk_st("resume", 4'b0100, 4);
    step(1); chk("resume_ph1", Tiempo, 4);
    step(1); chk("resume_ph2", Tiempo, 3);
    pulse_cancel(); chk_st("cancel_cal", 4'b0000, 0);

    // Cancel in PAUSA, with an adjust while paused.
    press_aj(); press_ca();
    @(negedge Clk) Puerta = 1'b1;
    @(negedge Clk) Puerta = 1'b0;
    chk_st("pausa", 4'b0010, 10);
    press_aj(); chk_st("pausa_adj", 4'b0010, 20);
    pulse_cancel(); chk_st("cancel_pausa", 4'b0000, 0);

    // Cancel in FIN.
    press_ca(); step(20); chk_st("fin2", 4'b1000, 0);
    pulse_cancel(); chk_st("cancel_fin", 4'b0000, 0);

    // Tick and pause on the same edge: both take effect.
    press_aj(); press_ca(); step(2);
    press_ca(); chk_st("tick_pause", 4'b0010, 9);
    pulse_cancel();

    // Final tick and door open on the same edge: FIN wins.
    press_ca(); step(19);
    Puerta = 1'b1;
    @(negedge Clk) chk_st("fin_vs_door", 4'b1000, 0);
    step(1); chk_st("fin_door_exit", 4'b0000, 0);
    Puerta = 1'b0;

    // Asynchronous reset mid-cook, with Ajust held through release.
    press_ca(); step(3);
    chk("precut_mag", Magnetron, 1);
    #1 begin reset = 1'b1; Ajust = 1'b1; end
    #1 chk_st("async_rst", 4'b0000, 0);
    chk("async_rst_mag", Magnetron, 0);
    @(negedge Clk) reset = 1'b0;
    step(3); chk_st("held_ajust", 4'b0000, 0);
    Ajust = 1'b0;
    press_aj(); chk_st("after_held", 4'b0001, 10);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
